// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, FSM states and default geometry for the data memory access unit
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;
  localparam int          DEF_MEM_WORDS = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_lane.sv
// rtl/dmem_lane.sv - little-endian lane extraction/extension and sub-word merge
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane, extend it for loads, and splice new data into it for stores
  always_comb begin
    w_byte  = i_word[{i_lane, 3'b000} +: 8];
    w_half  = i_lane[1] ? i_word[31:16] : i_word[15:0];
    o_load  = i_word;
    o_merge = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_load = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load = {{16{i_signed & w_half[15]}}, w_half};
        if (i_lane[1]) o_merge[31:16] = i_wdata;
        else           o_merge[15:0]  = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - load/store unit driving a word-only data memory with sub-word RMW
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_ena,
  output logic        mem_wena,
  output logic [31:0] mem_addr_in,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  // 33-bit limit so a range ending at the top of the address space does not wrap
  localparam logic [32:0] LIMIT_ADDR = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) << 2);

  state_t      r_state;
  state_t      w_state_next;

  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic [31:0] r_old_word;
  logic [31:0] r_addr;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic [15:0] r_wdata;

  logic        w_accept;
  logic        w_err;
  logic        w_rmw_start;
  logic [31:0] w_aligned;
  logic [31:0] w_lane_word;
  logic [1:0]  w_lane_idx;
  logic [1:0]  w_lane_size;
  logic        w_lane_signed;
  logic [15:0] w_lane_wdata;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign req_ready   = rst && (r_state == IDLE);
  assign w_accept    = req_valid && req_ready;
  assign w_aligned   = {req_addr[31:2], 2'b00};
  assign w_rmw_start = w_accept && !w_err && req_write && (req_size != SZ_WORD);

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

  // Reject reserved sizes, misaligned accesses and addresses outside the mapped window
  always_comb begin
    w_err = 1'b0;
    if (req_size == 2'b11)                           w_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])          w_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) w_err = 1'b1;
    if (req_addr < BASE_ADDR)                        w_err = 1'b1;
    if ({1'b0, req_addr} >= LIMIT_ADDR)              w_err = 1'b1;
  end

  // The lane unit serves the live load path in IDLE and the latched merge in RMW
  always_comb begin
    if (r_state == RMW) begin
      w_lane_word   = r_old_word;
      w_lane_idx    = r_lane;
      w_lane_size   = r_size;
      w_lane_signed = 1'b0;
      w_lane_wdata  = r_wdata;
    end else begin
      w_lane_word   = mem_data_out;
      w_lane_idx    = req_addr[1:0];
      w_lane_size   = req_size;
      w_lane_signed = req_signed;
      w_lane_wdata  = req_wdata[15:0];
    end
  end

  dmem_lane u_lane (
    .i_word   (w_lane_word),
    .i_lane   (w_lane_idx),
    .i_size   (w_lane_size),
    .i_signed (w_lane_signed),
    .i_wdata  (w_lane_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  // Next state and memory port drive; everything idles to zero and reset gates all accesses
  always_comb begin
    w_state_next = r_state;
    mem_ena      = 1'b0;
    mem_wena     = 1'b0;
    mem_addr_in  = 32'h0;
    mem_addr_out = 32'h0;
    mem_data_in  = 32'h0;
    if (rst) begin
      case (r_state)
        IDLE: begin
          if (w_accept && !w_err) begin
            mem_ena = 1'b1;
            if (req_write && req_size == SZ_WORD) begin
              mem_wena    = 1'b1;
              mem_addr_in = w_aligned;
              mem_data_in = req_wdata;
            end else begin
              mem_addr_out = w_aligned;
              if (req_write) w_state_next = RMW;
            end
          end
        end
        RMW: begin
          mem_ena      = 1'b1;
          mem_wena     = 1'b1;
          mem_addr_in  = r_addr;
          mem_data_in  = w_merge;
          w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State, response registers and the read-modify-write latches
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_old_word  <= 32'h0;
      r_addr      <= 32'h0;
      r_lane      <= 2'b00;
      r_size      <= SZ_BYTE;
      r_wdata     <= 16'h0;
    end else begin
      r_state     <= w_state_next;
      r_rsp_valid <= (w_accept && !w_rmw_start) || (r_state == RMW);
      r_rsp_err   <= w_accept && w_err;
      r_rsp_rdata <= (w_accept && !w_err && !req_write) ? w_load : 32'h0;
      if (w_rmw_start) begin
        r_old_word <= mem_data_out;
        r_addr     <= w_aligned;
        r_lane     <= req_addr[1:0];
        r_size     <= req_size;
        r_wdata    <= req_wdata[15:0];
      end
    end
  end

endmodule
